// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM encoding, nibble correction constants and sizing helpers.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_NIBBLE_W = 4;
    localparam int ADJ_THRESH   = 8;
    localparam int ADJ_OFFSET   = 3;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble:
// a nibble of 8 or more has 3 subtracted.
module bcd_digit_adjust
    import bcd2bin_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] nibble,
    output logic [BCD_NIBBLE_W-1:0] adjusted
);

    always_comb begin
        adjusted = nibble;
        if (nibble >= BCD_NIBBLE_W'(ADJ_THRESH)) begin
            adjusted = nibble - BCD_NIBBLE_W'(ADJ_OFFSET);
        end
    end

endmodule

// File: rtl/bcd2bin_seq_converter.sv
// Sequential BCD-to-binary converter, one reverse double-dabble
// shift per clock, with start/busy/done handshake.
module bcd2bin_seq_converter
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]               bin_out,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    if (pow10(DIGITS) > (64'd1 << BIN_W)) begin : g_width_check
        $error("BIN_W too narrow for DIGITS");
    end

    state_t             state;
    state_t             next_state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;
    logic               bad_flag;
    logic               invalid;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]   bcd_adj;

    always_comb begin
        invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] > 4'd9) begin
                invalid = 1'b1;
            end
        end
    end

    assign shifted = {bcd_reg, bin_reg} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nibble  (shifted[BIN_W+g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .adjusted(bcd_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = invalid ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bcd_reg  <= '0;
            bin_reg  <= '0;
            cnt      <= '0;
            bad_flag <= 1'b0;
            bin_out  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        bad_flag <= invalid;
                        bcd_reg  <= invalid ? '0 : bcd_in;
                        bin_reg  <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= shifted[BIN_W-1:0];
                    cnt     <= cnt + 1'b1;
                end
                DONE: begin
                    done    <= 1'b1;
                    err     <= bad_flag;
                    bin_out <= bad_flag ? '0 : bin_reg;
                end
                default: ;
            endcase
        end
    end

    // Every BCD bit must have been shifted out by the time DONE is reached.
    always_ff @(posedge clk) begin
        if (!rst && state == DONE && !bad_flag) begin
            assert (bcd_reg == '0)
            else $error("bcd_reg not empty after final shift");
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd2bin_seq_converter.sv
// Self-checking bench for bcd2bin_seq_converter: directed cases
// plus random operands against an arithmetic reference model.
module tb_bcd2bin_seq_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk;
    int n_fail;

    bcd2bin_seq_converter #(
        .DIGITS(4),
        .BIN_W (14)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd_in (bcd_in),
        .bin_out(bin_out),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_conv(input logic [15:0] v,
                                     output int val, output bit bad);
        int d;
        val = 0;
        bad = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endfunction

    // Called at a negedge with the DUT idle; returns at the done negedge.
    task automatic run_tx(input logic [15:0] v, input bit hold);
        int lat;
        int bcnt;
        int exp_v;
        bit exp_bad;
        ref_conv(v, exp_v, exp_bad);
        start  = 1'b1;
        bcd_in = v;
        @(posedge clk);
        lat  = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            start  = hold;
            bcd_in = 16'($urandom);
            if (busy) bcnt++;
            if (done) break;
            if (lat == 40) break;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, exp_bad ? 1 : 15);
        check("done", int'(done), 1);
        check("bin_out", int'(bin_out), exp_v);
        check("err", int'(err), int'(exp_bad));
        check("busy_cycles", bcnt, exp_bad ? 1 : 15);
    endtask

    task automatic idle_quiet(input int n, input string tag);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check(tag, dones, 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        logic [15:0] v;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);

        run_tx(16'h0000, 1'b0);
        run_tx(16'h9999, 1'b0);
        run_tx(16'h1234, 1'b0);
        run_tx(16'h0010, 1'b0);
        run_tx(16'h12A4, 1'b0);
        run_tx(16'h0042, 1'b0);
        run_tx(16'h0500, 1'b1);
        idle_quiet(20, "extra_done");

        start  = 1'b1;
        bcd_in = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_bin_out", int'(bin_out), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_err", int'(err), 0);
        idle_quiet(20, "abandoned_done");
        run_tx(16'h7777, 1'b0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(3) == 0) begin
                v = 16'($urandom);
            end else begin
                v = {4'($urandom_range(9)), 4'($urandom_range(9)),
                     4'($urandom_range(9)), 4'($urandom_range(9))};
            end
            repeat ($urandom_range(2)) @(negedge clk);
            run_tx(v, 1'($urandom_range(1)));
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
